// File: rtl/fsm_data_collector.sv
// Collects data1/data2 samples from an upstream FSM into a FIFO and hands them to a
// ready/valid consumer, pulsing o_release once the frame has fully drained.
module fsm_data_collector #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_state,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_tag,
    output logic          o_release,
    output logic          o_overflow,
    output logic [7:0]    o_drop_cnt,
    output logic [7:0]    o_frame_cnt,
    output logic          o_illegal
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] UP_STATE1 = 4'b0000;
    localparam logic [3:0] UP_STATE2 = 4'b0001;
    localparam logic [3:0] UP_STATE3 = 4'b0010;
    localparam logic [3:0] UP_STATE4 = 4'b0100;

    typedef enum logic [2:0] {
        IDLE,
        CAP1,
        CAP2,
        DRAIN,
        REL
    } ctrl_e;

    ctrl_e          state_q, state_d;
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [DW:0]    mem_q [DEPTH];
    logic           overflow_q, illegal_q;
    logic [7:0]     drop_cnt_q, frame_cnt_q;

    logic           up_s1, up_s2, up_s3, up_s4;
    logic           empty, full, push_req, push_ok, pop, drop;
    logic [DW:0]    push_word, head_word;

    assign up_s1 = (i_state == UP_STATE1);
    assign up_s2 = (i_state == UP_STATE2);
    assign up_s3 = (i_state == UP_STATE3);
    assign up_s4 = (i_state == UP_STATE4);

    // Extra pointer MSB tells full from empty when the index bits coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_req  = (up_s2 && (state_q == IDLE || state_q == CAP1)) ||
                       (up_s3 && (state_q == CAP1 || state_q == CAP2));
    assign push_word = up_s3 ? {1'b1, i_data2} : {1'b0, i_data1};
    assign pop       = !empty && i_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (up_s2) state_d = CAP1;
            CAP1:  if (up_s3) state_d = CAP2;
                   else if (up_s1) state_d = IDLE;
            CAP2:  if (up_s4) state_d = DRAIN;
                   else if (up_s1) state_d = IDLE;
            DRAIN: if (empty && !push_req) state_d = REL;
            REL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            drop_cnt_q  <= 8'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (state_q == REL) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (!(up_s1 || up_s2 || up_s3 || up_s4)) illegal_q <= 1'b1;
        end
    end

    // NOTE: storage is not reset; resetting the pointers is enough to mark it empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

    assign head_word   = mem_q[rd_ptr_q[AW-1:0]];
    assign o_valid     = !empty;
    assign o_data      = head_word[DW-1:0];
    assign o_tag       = head_word[DW];
    assign o_release   = (state_q == REL);
    assign o_overflow  = overflow_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_fsm_data_collector.sv
// Randomized plus directed bench for fsm_data_collector, checked every cycle against a
// queue-based behavioural model of the collector.
module tb_fsm_data_collector;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    localparam logic [3:0] S1 = 4'b0000;
    localparam logic [3:0] S2 = 4'b0001;
    localparam logic [3:0] S3 = 4'b0010;
    localparam logic [3:0] S4 = 4'b0100;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    i_state;
    logic [DW-1:0] i_data1, i_data2;
    logic          i_ready;
    logic          o_valid, o_tag, o_release, o_overflow, o_illegal;
    logic [DW-1:0] o_data;
    logic [7:0]    o_drop_cnt, o_frame_cnt;

    fsm_data_collector #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_state     (i_state),
        .i_data1     (i_data1),
        .i_data2     (i_data2),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_tag       (o_tag),
        .o_release   (o_release),
        .o_overflow  (o_overflow),
        .o_drop_cnt  (o_drop_cnt),
        .o_frame_cnt (o_frame_cnt),
        .o_illegal   (o_illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: collector phase, FIFO as a queue, plain counters.
    typedef enum int {M_IDLE, M_CAP1, M_CAP2, M_DRAIN, M_REL} phase_e;
    phase_e        m_phase = M_IDLE;
    logic [DW:0]   m_q[$];
    logic [DW:0]   m_log[$];
    bit            m_ovf = 0, m_ill = 0;
    int            m_drops = 0, m_frames = 0;
    bit            started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_IDLE; m_q.delete();
            m_ovf = 0; m_ill = 0; m_drops = 0; m_frames = 0;
        end else begin
            bit legal, push, pop, was_empty;
            legal     = (i_state inside {S1, S2, S3, S4});
            was_empty = (m_q.size() == 0);
            push = (i_state == S2 && m_phase inside {M_IDLE, M_CAP1}) ||
                   (i_state == S3 && m_phase inside {M_CAP1, M_CAP2});
            pop  = !was_empty && i_ready;
            if (!legal) m_ill = 1;
            if (push && m_q.size() == DEPTH && !pop) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
                push = 0;
            end
            if (pop) m_log.push_back(m_q.pop_front());
            if (push) m_q.push_back(i_state == S3 ? {1'b1, i_data2} : {1'b0, i_data1});
            case (m_phase)
                M_IDLE:  if (i_state == S2) m_phase = M_CAP1;
                M_CAP1:  if (i_state == S3) m_phase = M_CAP2;
                         else if (i_state == S1) m_phase = M_IDLE;
                M_CAP2:  if (i_state == S4) m_phase = M_DRAIN;
                         else if (i_state == S1) m_phase = M_IDLE;
                M_DRAIN: if (was_empty && !push) m_phase = M_REL;
                M_REL:   begin m_frames = (m_frames + 1) % 256; m_phase = M_IDLE; end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("valid", o_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("data", o_data, m_q[0][DW-1:0]);
                check("tag", o_tag, m_q[0][DW]);
            end
            check("release", o_release, m_phase == M_REL);
            check("overflow", o_overflow, m_ovf);
            check("illegal", o_illegal, m_ill);
            check("drop_cnt", o_drop_cnt, m_drops);
            check("frame_cnt", o_frame_cnt, m_frames);
        end
    end

    // Drive one cycle's inputs; returns just after the edge that sampled them.
    task automatic step(input logic [3:0] st, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic rdy, input logic rs = 1'b0);
        rst = rs; i_state = st; i_data1 = d1; i_data2 = d2; i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(S1, '0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        started = 1;
    endtask

    initial begin
        int rel_seen;
        rst = 1'b1; i_state = S1; i_data1 = '0; i_data2 = '0; i_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("rst_valid", o_valid, 1'b0);
        check("rst_frame", o_frame_cnt, 8'd0);

        // Basic frame: 5 data1, 3 data2, then STATE4 with a ready consumer.
        m_log.delete();
        for (int i = 0; i < 5; i++) step(S2, DW'(i), '0, 1'b1);
        for (int i = 0; i < 3; i++) step(S3, '0, DW'(i), 1'b1);
        rel_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(S4, '0, '0, 1'b1);
            if (o_release) rel_seen++;
        end
        check("frame_release_pulses", rel_seen, 1);
        check("frame_cnt_after_frame", o_frame_cnt, 8'd1);
        check("frame_word_count", m_log.size(), 8);
        if (m_log.size() == 8)
            for (int i = 0; i < 8; i++)
                check("frame_word_order", m_log[i], (i < 5) ? {1'b0, DW'(i)} : {1'b1, DW'(i - 5)});

        // Overflow: 20 data1 pushes with no consumer.
        do_reset();
        for (int i = 0; i < 20; i++) step(S2, DW'(8'hA0 + i), '0, 1'b0);
        check("ovf_valid", o_valid, 1'b1);
        check("ovf_flag", o_overflow, 1'b1);
        check("ovf_drops", o_drop_cnt, 8'd4);
        check("ovf_head", o_data, 8'hA0);

        // Full FIFO with concurrent pop and push keeps full throughput, no new drops.
        step(S3, '0, 8'h50, 1'b1);
        for (int i = 1; i < 10; i++) begin
            step(S3, '0, DW'(8'h50 + i), 1'b1);
            check("full_pop_valid", o_valid, 1'b1);
        end
        check("full_pop_drops", o_drop_cnt, 8'd4);
        step(S1, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) step(S1, '0, '0, 1'b1);
        check("ovf_drained", o_valid, 1'b0);

        // Release only after the third pop with a toggling consumer.
        do_reset();
        step(S2, 8'h11, '0, 1'b0);
        step(S3, '0, 8'h22, 1'b0);
        step(S3, '0, 8'h33, 1'b0);
        step(S4, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(S4, '0, '0, (i % 2) == 0);
            check("toggle_no_release", o_release, 1'b0);
        end
        step(S4, '0, '0, 1'b1);
        check("toggle_release", o_release, 1'b1);
        step(S4, '0, '0, 1'b1);
        check("toggle_release_end", o_release, 1'b0);

        // Illegal code during CAP1: flagged, not captured, controller stays in CAP1.
        do_reset();
        step(S2, 8'h01, '0, 1'b0);
        step(4'b1000, 8'h02, 8'h03, 1'b0);
        check("illegal_flag", o_illegal, 1'b1);
        step(S3, '0, 8'h04, 1'b0);
        step(S1, '0, '0, 1'b0);
        check("illegal_stays_cap1", m_q.size(), 2);

        // Reset mid-frame with 6 words queued in CAP2.
        do_reset();
        for (int i = 0; i < 3; i++) step(S2, DW'(i), '0, 1'b0);
        for (int i = 0; i < 3; i++) step(S3, '0, DW'(i), 1'b0);
        step(S3, '0, '0, 1'b0, 1'b1);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_release", o_release, 1'b0);
        check("midrst_drops", o_drop_cnt, 8'd0);
        check("midrst_frames", o_frame_cnt, 8'd0);
        step(S3, '0, 8'h77, 1'b0);
        step(S1, '0, '0, 1'b0);
        check("midrst_idle_no_push", o_valid, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] st;
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       st = {1'b1, 3'($urandom)};
            else if (r < 20) st = S1;
            else if (r < 50) st = S2;
            else if (r < 78) st = S3;
            else             st = S4;
            step(st, DW'($urandom), DW'($urandom),
                 (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 299) == 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_data_collector.md
FSM_DATA_COLLECTOR -- requirements
Module: fsm_data_collector

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 Parameter DW, default 8, data width of each captured sample.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_state  input  4  upstream FSM state code: 4'b0000 STATE1, 4'b0001 STATE2, 4'b0010 STATE3, 4'b0100 STATE4; any other value is illegal.
REQ-006 i_data1  input  DW  upstream data1 stream, sampled only while i_state==STATE2.
REQ-007 i_data2  input  DW  upstream data2 stream, sampled only while i_state==STATE3.
REQ-008 o_valid  output  1  output word available.
REQ-009 i_ready  input  1  consumer accepts the output word.
REQ-010 o_data  output  DW  output sample (FIFO head).
REQ-011 o_tag  output  1  source of o_data: 0 = data1, 1 = data2.
REQ-012 o_release  output  1  one-cycle pulse driving the upstream state4_to_state1 input.
REQ-013 o_overflow  output  1  sticky flag: a sample was dropped.
REQ-014 o_drop_cnt  output  8  count of dropped samples, saturating at 255.
REQ-015 o_frame_cnt  output  8  count of completed frames, wrapping 255->0.
REQ-016 o_illegal  output  1  sticky flag: illegal i_state code seen.

Function
REQ-017 Controller states: IDLE, CAP1, CAP2, DRAIN, REL; one state register.
REQ-018 IDLE->CAP1 when i_state==STATE2; CAP1->CAP2 when i_state==STATE3; CAP2->DRAIN when i_state==STATE4.
REQ-019 DRAIN->REL when the FIFO is empty and no push occurs in that cycle; REL->IDLE on the next cycle unconditionally.
REQ-020 In REL only, o_release=1; exactly one pulse per frame.
REQ-021 o_frame_cnt increments by 1 in the cycle REL is occupied.
REQ-022 Push {tag=0,i_data1} every cycle in which i_state==STATE2 and the controller is in IDLE or CAP1.
REQ-023 Push {tag=1,i_data2} every cycle in which i_state==STATE3 and the controller is in CAP1 or CAP2.
REQ-024 Capture decisions use the current-cycle i_state (zero-cycle sampling); the written entry is visible at the FIFO head on the following cycle at the earliest.
REQ-025 Pop occurs when o_valid & i_ready; o_valid = FIFO not empty; o_data/o_tag are stable while o_valid=1 and i_ready=0.
REQ-026 FIFO has no fall-through: a push into an empty FIFO raises o_valid one cycle later.
REQ-027 Full FIFO with a push and no pop in the same cycle: sample dropped, o_overflow set, o_drop_cnt incremented (saturating at 255).
REQ-028 Full FIFO with a push and a pop in the same cycle: push accepted, occupancy unchanged, no drop.
REQ-029 Empty FIFO with a push and i_ready=1: no pop (o_valid=0); occupancy becomes 1.
REQ-030 Read/write pointers are log2(DEPTH)+1 bits; full/empty derived from pointer comparison; wrap-around is transparent.
REQ-031 Any i_state not among the four legal codes sets o_illegal, is not captured, and causes no controller transition.
REQ-032 i_state returning to STATE1 while the controller is in CAP1 or CAP2 sends the controller to IDLE; FIFO contents are kept and o_release is not pulsed.

Reset
REQ-033 Reset values: controller IDLE, FIFO empty, pointers 0, o_valid=0, o_release=0, o_overflow=0, o_illegal=0, o_drop_cnt=0, o_frame_cnt=0.
REQ-034 Reset asserted mid-frame discards all FIFO contents in the same edge; no o_release pulse is produced.
REQ-035 o_data and o_tag are don't-care while o_valid=0.

Verification
REQ-036 i_state STATE2 for 5 cycles with i_data1=0..4, then STATE3 for 3 cycles with i_data2=0..2, then STATE4; i_ready=1 -> 8 words out in order, tags 0,0,0,0,0,1,1,1; one o_release pulse; o_frame_cnt=1.
REQ-037 DEPTH=16, i_ready=0, STATE2 for 20 cycles -> o_valid=1, o_overflow=1, o_drop_cnt=4; the 16 stored words read back correctly.
REQ-038 FIFO full, i_ready=1, continuous STATE3 pushes -> o_drop_cnt unchanged and throughput 1 word/cycle.
REQ-039 In STATE4 with 3 words queued and i_ready toggling 1,0,1,0,1 -> o_release fires exactly once, only after the third pop.
REQ-040 i_state=4'b1000 for 1 cycle during CAP1 -> o_illegal=1, no push, controller stays in CAP1.
REQ-041 rst for 1 cycle with 6 words queued in CAP2 -> next cycle o_valid=0, controller in IDLE, all counters 0.
